// File: rtl/serial_compare_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot {gt, eq, lt}; all-zero marks a comparator fault.
    typedef logic [2:0] res_t;

    localparam res_t RES_GT  = 3'b100;
    localparam res_t RES_EQ  = 3'b010;
    localparam res_t RES_LT  = 3'b001;
    localparam res_t RES_ERR = 3'b000;

    function automatic int step_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_if.sv
// Operand request and result response channels of serial_compare_ctrl.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    import serial_compare_pkg::*;

    localparam int STEP_W = step_w(WIDTH);

    logic              start_valid;
    logic              start_ready;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              res_valid;
    logic              res_ready;
    logic              gt;
    logic              eq;
    logic              lt;
    logic [STEP_W-1:0] steps;
    logic              busy;

    modport master (
        output start_valid, a_in, b_in, res_ready,
        input  start_ready, res_valid, gt, eq, lt, steps, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, res_ready,
        output start_ready, res_valid, gt, eq, lt, steps, busy
    );

endinterface

// File: rtl/one_bit_comparator.sv
// Single bit-pair comparator; o2 is a signed flag that is nonzero when a equals b.
module one_bit_comparator (
    input  logic              a,
    input  logic              b,
    output logic              o1,
    output logic signed [7:0] o2,
    output logic              o3
);

    assign o1 = a & ~b;
    assign o3 = ~a & b;
    assign o2 = (a == b) ? 8'sd1 : 8'sd0;

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude compare, MSB first, stopping at the first differing bit.
module serial_compare_ctrl
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 clr,
    serial_compare_ctrl_if.slave bus
);

    localparam int STEP_W = step_w(WIDTH);
    localparam int IDX_W  = idx_w(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [IDX_W-1:0]  idx_q;
    logic [STEP_W-1:0] steps_q;
    res_t              res_q, res_d;

    logic              accept, handshake, scan_done;
    logic              cmp_gt, cmp_lt, cmp_eq;
    logic signed [7:0] cmp_o2;

    one_bit_comparator u_cmp (
        .a  (a_reg[idx_q]),
        .b  (b_reg[idx_q]),
        .o1 (cmp_gt),
        .o2 (cmp_o2),
        .o3 (cmp_lt)
    );

    assign cmp_eq = (cmp_o2 != 8'sd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        handshake = 1'b0;
        scan_done = 1'b0;
        res_d     = RES_ERR;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                case ({cmp_gt, cmp_eq, cmp_lt})
                    3'b100: begin
                        scan_done = 1'b1;
                        res_d     = RES_GT;
                    end
                    3'b001: begin
                        scan_done = 1'b1;
                        res_d     = RES_LT;
                    end
                    3'b010: begin
                        if (idx_q == '0) begin
                            scan_done = 1'b1;
                            res_d     = RES_EQ;
                        end
                    end
                    // A broken comparator ends the scan with an all-zero result.
                    default: begin
                        scan_done = 1'b1;
                        res_d     = RES_ERR;
                    end
                endcase
                if (scan_done) state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d   = IDLE;
            accept    = 1'b0;
            handshake = 1'b0;
            scan_done = 1'b0;
        end
    end

    // NOTE: operand registers are reset as well, so a dropped operation leaves
    // no stale operands behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            res_q   <= RES_ERR;
        end else if (clr) begin
            a_reg   <= '0;
            b_reg   <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            res_q   <= RES_ERR;
        end else begin
            if (accept) begin
                a_reg   <= bus.a_in;
                b_reg   <= bus.b_in;
                idx_q   <= IDX_W'(WIDTH - 1);
                steps_q <= '0;
            end
            if (state_q == SCAN) begin
                steps_q <= steps_q + STEP_W'(1);
                if (scan_done) res_q <= res_d;
                else           idx_q <= idx_q - IDX_W'(1);
            end
            if (handshake) res_q <= RES_ERR;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == SCAN);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.gt          = res_q[2];
    assign bus.eq          = res_q[1];
    assign bus.lt          = res_q[0];
    assign bus.steps       = steps_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: vector table plus abort/reset/backpressure sequences.
module tb_serial_compare_ctrl;
    import serial_compare_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        res_t             res;
        int               steps;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t dut_res();
        return {bus.gt, bus.eq, bus.lt};
    endfunction

    // Accept an operand pair, then count edges until res_valid rises.
    task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output int cyc);
        bus.a_in        = a;
        bus.b_in        = b;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        cyc = 0;
        while (bus.res_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int cyc;
        check({name, "_start_ready"}, bus.start_ready, 1'b1);
        start_and_wait(v.a, v.b, cyc);
        check({name, "_latency"}, cyc, v.steps);
        check({name, "_result"}, dut_res(), v.res);
        check({name, "_steps"}, bus.steps, v.steps);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({name, "_post_valid"}, bus.res_valid, 1'b0);
        check({name, "_post_result"}, dut_res(), RES_ERR);
        check({name, "_post_ready"}, bus.start_ready, 1'b1);
    endtask

    vec_t vecs[9];

    initial begin
        int  cyc;
        logic seen;

        vecs[0] = '{8'hA5, 8'hA5, RES_EQ, 8};
        vecs[1] = '{8'h80, 8'h7F, RES_GT, 1};
        vecs[2] = '{8'h7F, 8'h80, RES_LT, 1};
        vecs[3] = '{8'h3C, 8'h34, RES_GT, 5};
        vecs[4] = '{8'h12, 8'h13, RES_LT, 8};
        vecs[5] = '{8'h01, 8'h00, RES_GT, 8};
        vecs[6] = '{8'hFF, 8'h00, RES_GT, 1};
        vecs[7] = '{8'h00, 8'h00, RES_EQ, 8};
        vecs[8] = '{8'h5A, 8'h5E, RES_LT, 6};

        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;

        #23 rst_n = 1'b1;
        tick();
        check("rst_start_ready", bus.start_ready, 1'b1);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_result", dut_res(), RES_ERR);
        check("rst_steps", bus.steps, 0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held while new operands wait outside.
        start_and_wait(8'h3C, 8'h34, cyc);
        check("bp_latency", cyc, 5);
        bus.start_valid = 1'b1;
        bus.a_in        = 8'hFF;
        bus.b_in        = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), bus.res_valid, 1'b1);
            check($sformatf("bp_hold_result%0d", i), dut_res(), RES_GT);
            check($sformatf("bp_hold_steps%0d", i), bus.steps, 5);
            check($sformatf("bp_hold_ready%0d", i), bus.start_ready, 1'b0);
        end
        bus.a_in      = 8'h00;
        bus.b_in      = 8'hFF;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_release_valid", bus.res_valid, 1'b0);
        check("bp_release_busy", bus.busy, 1'b0);
        check("bp_release_ready", bus.start_ready, 1'b1);
        tick();
        bus.start_valid = 1'b0;
        check("bp_accept_busy", bus.busy, 1'b1);
        cyc = 0;
        while (bus.res_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("bp_new_latency", cyc, 1);
        check("bp_new_result", dut_res(), RES_LT);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // clr on the third SCAN cycle.
        bus.a_in        = 8'hA5;
        bus.b_in        = 8'hA5;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", bus.busy, 1'b0);
        check("clr_ready", bus.start_ready, 1'b1);
        check("clr_steps", bus.steps, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        check("clr_no_result", seen, 1'b0);

        // Asynchronous reset mid-SCAN, applied between clock edges.
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_valid", bus.res_valid, 1'b0);
        check("arst_steps", bus.steps, 0);
        check("arst_result", dut_res(), RES_ERR);
        check("arst_ready", bus.start_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("post_rst", '{8'h01, 8'h00, RES_GT, 8});

        // clr together with a start request in IDLE.
        bus.a_in        = 8'h80;
        bus.b_in        = 8'h7F;
        bus.start_valid = 1'b1;
        clr             = 1'b1;
        tick();
        clr             = 1'b0;
        bus.start_valid = 1'b0;
        check("clr_start_busy", bus.busy, 1'b0);
        check("clr_start_ready", bus.start_ready, 1'b1);

        // clr together with res_ready in DONE.
        start_and_wait(8'h80, 8'h7F, cyc);
        check("clr_done_latency", cyc, 1);
        clr           = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        clr           = 1'b0;
        bus.res_ready = 1'b0;
        check("clr_done_valid", bus.res_valid, 1'b0);
        check("clr_done_result", dut_res(), RES_ERR);
        check("clr_done_steps", bus.steps, 0);
        check("clr_done_ready", bus.start_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
- Sequencer that performs a WIDTH-bit unsigned magnitude comparison by driving a single one_bit_comparator instance one bit pair per cycle, MSB first.
- Operands are accepted through a valid/ready handshake, scanned with early termination on the first differing bit, and returned as a one-hot gt/eq/lt result through a second valid/ready handshake.
- Used wherever area matters more than compare latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..64.
- STEP_W, $clog2(WIDTH+1), width of the steps output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; returns to IDLE and discards any result.
- start_valid  input  1  operands valid.
- start_ready  output  1  high only in IDLE.
- a_in  input  WIDTH  operand A, unsigned.
- b_in  input  WIDTH  operand B, unsigned.
- res_valid  output  1  result valid; high only in DONE.
- res_ready  input  1  consumer accepts result.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.
- steps  output  STEP_W  number of bit pairs compared, 1..WIDTH.
- busy  output  1  high in SCAN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - start_ready=1 after release; res_valid, busy, gt, eq, lt = 0; steps = 0.
  - Operand registers and bit index are cleared.
  - Reset mid-SCAN or mid-DONE drops the operation with no result.
- States IDLE, SCAN, DONE:
  - IDLE: start_ready=1. On start_valid at an edge, latch a_in/b_in, set idx=WIDTH-1, clear steps, go to SCAN.
  - SCAN: a_reg[idx] and b_reg[idx] drive the comparator's A and B. Each cycle steps increments.
    - o1=1: gt=1, go to DONE.
    - o3=1: lt=1, go to DONE.
    - Equal with idx==0: eq=1, go to DONE.
    - Otherwise: idx decrements and the state stays in SCAN.
  - DONE: res_valid=1; gt/eq/lt/steps held stable. On res_ready, go to IDLE and clear gt/eq/lt/res_valid at that edge.
- Latency:
  - Let m = number of leading equal bits.
  - res_valid rises m+1 cycles after the accept edge when the operands differ, and WIDTH cycles after when they are equal.
  - Minimum accept-to-accept interval is steps+2 cycles: no start is accepted in the same cycle as a result handshake.
- Comparator interface:
  - o2 is signed 8-bit, nonzero when the bits are equal; the controller tests o2 != 0.
  - Exactly one of o1 / (o2!=0) / o3 holds. An illegal combination in SCAN (none or more than one) forces DONE with gt=eq=lt=0 and res_valid=1. The bench can check this; it is unreachable with a correct comparator.
- Output invariants:
  - gt/eq/lt are one-hot whenever res_valid=1.
  - gt/eq/lt are all zero otherwise.
- Handshake rules:
  - start_valid outside IDLE is ignored; a_in/b_in are sampled only at accept.
  - res_valid never drops without res_ready, except on clr or rst_n.
- clr priority:
  - clr overrides all other inputs, including a same-cycle start accept or res_ready.
  - Next state is IDLE with outputs at their reset values.
- WIDTH=1: SCAN lasts exactly one cycle; steps=1.
- Arithmetic: idx is $clog2(WIDTH) bits (minimum 1); steps saturates at WIDTH by construction; no wrap-around occurs.

Decomposition:
- Package serial_compare_pkg:
  - State enum: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - Result-code constants RES_GT, RES_EQ, RES_LT, RES_ERR for bench checking.
  - A function computing STEP_W.
- One sub-module: one_bit_comparator (existing block), instantiated once; all sequencing lives in serial_compare_ctrl.

Test Plan:
- Equal operands: a=8'hA5, b=8'hA5, res_ready=1 → eq=1, gt=lt=0, steps=8, res_valid 8 cycles after accept, start_ready back high one cycle after the result handshake.
- MSB decides: a=8'h80, b=8'h7F → gt=1, steps=1, res_valid 1 cycle after accept. Swapped operands → lt=1, steps=1.
- Mid bit decides:
  - a=8'h3C, b=8'h34 → gt=1, steps=5.
  - a=8'h12, b=8'h13 → lt=1, steps=8.
- Backpressure: result pending with res_ready=0 for 5 cycles while start_valid=1 with new operands → res_valid, gt/eq/lt and steps stable; start_ready=0; new operands not latched. res_ready=1 → IDLE next cycle, then the new operands are accepted.
- Abort and reset:
  - clr=1 on the 3rd SCAN cycle → IDLE next edge, res_valid never asserts, busy=0.
  - rst_n low mid-SCAN → all outputs reset immediately, without waiting for a clock edge.
  - After release, a=8'h01, b=8'h00 → gt=1, steps=8.
- Simultaneous events: clr=1 in the same cycle as start_valid=1 in IDLE → no accept, state stays IDLE. clr=1 together with res_ready in DONE → IDLE, outputs cleared.
